// File: rtl/arb_rr_bin_if.sv
// Request/grant bundle between the requesters, the round-robin arbiter and
// the downstream binary-select mux. The arbiter uses the slave modport; the
// requester/consumer side uses the master modport.
interface arb_rr_bin_if #(
  parameter int WIDTH = 32
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req;
  logic                 gnt_vld;
  logic                 gnt_rdy;
  logic [WIDTH_LOG-1:0] gnt_bin;
  logic [WIDTH-1:0]     gnt_oht;

  modport master (
    output req,
    output gnt_rdy,
    input  gnt_vld,
    input  gnt_bin,
    input  gnt_oht
  );

  modport slave (
    input  req,
    input  gnt_rdy,
    output gnt_vld,
    output gnt_bin,
    output gnt_oht
  );
endinterface

// File: rtl/arb_rr_bin.sv
// Round-robin arbiter with a registered binary grant (mux select) plus a
// one-hot copy. A grant is held unchanged until the consumer accepts it, so
// the downstream mux output stays stable through a stall. The priority
// pointer advances only on acceptance, to one past the accepted index.
module arb_rr_bin #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  arb_rr_bin_if.slave bus
);
  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SUM_W     = WIDTH_LOG + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH_LOG-1:0] r_ptr;
  logic [WIDTH_LOG-1:0] r_gnt_bin;
  logic [WIDTH-1:0]     r_gnt_oht;

  logic                 w_accept;
  logic                 w_any;
  logic [WIDTH_LOG-1:0] w_ptr_next;
  logic [WIDTH_LOG-1:0] w_arb_ptr;
  logic [WIDTH_LOG-1:0] w_sel_idx;
  logic [WIDTH-1:0]     w_sel_oht;
  logic                 w_found;
  logic [SUM_W-1:0]     w_sum;
  logic [WIDTH_LOG-1:0] w_idx;

  assign w_accept = (r_state == GRANT) && bus.gnt_rdy;
  assign w_any    = |bus.req;

  // Explicit wrap keeps the pointer inside 0..WIDTH-1 for non-power-of-two WIDTH.
  assign w_ptr_next = (r_gnt_bin == WIDTH_LOG'(WIDTH - 1)) ? '0
                                                            : r_gnt_bin + WIDTH_LOG'(1);

  // Re-arbitrating in the accepting cycle must already see the advanced
  // pointer, which puts the just-served requester at lowest priority.
  assign w_arb_ptr = w_accept ? w_ptr_next : r_ptr;

  // Circular first-set scan starting at the effective pointer.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_sum = {1'b0, w_arb_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(WIDTH)) begin
        w_sum = w_sum - SUM_W'(WIDTH);
      end
      w_idx = w_sum[WIDTH_LOG-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = w_idx;
      end
    end
  end

  assign w_sel_oht = {{(WIDTH-1){1'b0}}, 1'b1} << w_sel_idx;

  // Grant FSM: issues, holds and retires grants and advances the pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt_bin <= '0;
      r_gnt_oht <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= GRANT;
            r_gnt_bin <= w_sel_idx;
            r_gnt_oht <= w_sel_oht;
          end
        end
        GRANT: begin
          if (bus.gnt_rdy) begin
            r_ptr <= w_ptr_next;
            if (w_any) begin
              r_gnt_bin <= w_sel_idx;
              r_gnt_oht <= w_sel_oht;
            end else begin
              r_state   <= IDLE;
              r_gnt_oht <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_vld = (r_state == GRANT);
  assign bus.gnt_bin = r_gnt_bin;
  assign bus.gnt_oht = r_gnt_oht;
endmodule
